// File: rtl/rc_position_mapper.sv
// rc_position_mapper
// Turns RC channel updates (channels 0..3) into four slew-limited Dynamixel
// goal positions and paces sync-write frames at a fixed period. Frames are
// suppressed while the radio link is considered lost.
module rc_position_mapper #(
  parameter int unsigned clocks_per_update = 2000,
  parameter int unsigned timeout_clocks    = 1000000,
  parameter int unsigned channel_center    = 992,
  parameter int unsigned scale             = 40,
  parameter int unsigned pos_center        = 2048,
  parameter int unsigned pos_min           = 0,
  parameter int unsigned pos_max           = 4095,
  parameter int unsigned max_step          = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        channel_changed,
  input  logic [3:0]  channel_index,
  input  logic [10:0] channel_value,
  input  logic        writer_busy,
  output logic        send,
  output logic [31:0] position1,
  output logic [31:0] position2,
  output logic [31:0] position3,
  output logic [31:0] position4,
  output logic        failsafe
);

  localparam int PERIOD_W  = (clocks_per_update > 1) ? $clog2(clocks_per_update) : 1;
  localparam int TIMEOUT_W = $clog2(timeout_clocks + 1);
  localparam logic [PERIOD_W-1:0]  PERIOD_LAST   = PERIOD_W'(clocks_per_update - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(timeout_clocks);
  localparam logic [11:0]          POS_CENTER12  = 12'(pos_center);
  localparam logic signed [12:0]   STEP_HI       = 13'(max_step);
  localparam logic signed [12:0]   STEP_LO       = -STEP_HI;
  localparam logic signed [20:0]   CLAMP_LO      = 21'(pos_min);
  localparam logic signed [20:0]   CLAMP_HI      = 21'(pos_max);

  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_WAIT, ST_SEND} state_t;

  state_t state_reg, state_next;

  // Target pipeline registers
  logic               s1_valid_reg;
  logic [3:0]         s1_index_reg;
  logic [10:0]        s1_value_reg;
  logic               s2_valid_reg;
  logic [3:0]         s2_index_reg;
  logic signed [19:0] s2_prod_reg;

  logic signed [11:0] diff_c;
  logic signed [19:0] prod_c;
  logic signed [19:0] shifted_c;
  logic signed [20:0] sum_c;
  logic [11:0]        tgt_value;
  logic               tgt_wr_en;

  // Timers and frame control
  logic [PERIOD_W-1:0]  period_cnt_reg;
  logic [TIMEOUT_W-1:0] timeout_cnt_reg;
  logic                 failsafe_reg;
  logic                 pending_reg;
  logic                 tick;
  logic                 frame_req;
  logic [1:0]           step_k_reg;
  logic                 step_en;

  // Per-channel state gathered into flat vectors for the STEP mux
  logic [47:0]        target_flat;
  logic [47:0]        pos_flat;
  logic [11:0]        cur_pos;
  logic [11:0]        cur_tgt;
  logic signed [12:0] step_delta;
  logic [11:0]        step_pos;

  // Stage 1: capture the strobe, stage 2: register the scaled offset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_index_reg <= '0;
      s1_value_reg <= '0;
      s2_valid_reg <= 1'b0;
      s2_index_reg <= '0;
      s2_prod_reg  <= '0;
    end else begin
      s1_valid_reg <= channel_changed;
      s1_index_reg <= channel_index;
      s1_value_reg <= channel_value;
      s2_valid_reg <= s1_valid_reg;
      s2_index_reg <= s1_index_reg;
      s2_prod_reg  <= prod_c;
    end
  end

  // Offset from center times gain, then recenter, shift out the Q4 fraction and clamp
  always_comb begin
    diff_c    = $signed({1'b0, s1_value_reg}) - $signed(12'(channel_center));
    prod_c    = $signed({{8{diff_c[11]}}, diff_c}) * $signed(20'(scale));
    shifted_c = s2_prod_reg >>> 4;
    sum_c     = $signed(21'(pos_center)) + $signed({shifted_c[19], shifted_c});
    if (sum_c < CLAMP_LO) begin
      tgt_value = 12'(pos_min);
    end else if (sum_c > CLAMP_HI) begin
      tgt_value = 12'(pos_max);
    end else begin
      tgt_value = sum_c[11:0];
    end
    tgt_wr_en = s2_valid_reg && (s2_index_reg < 4'd4);
  end

  // Free-running frame period counter; tick marks the wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_reg <= '0;
    end else if (tick) begin
      period_cnt_reg <= '0;
    end else begin
      period_cnt_reg <= period_cnt_reg + PERIOD_W'(1);
    end
  end

  assign tick      = (period_cnt_reg == PERIOD_LAST);
  assign frame_req = tick || pending_reg;

  // Link watchdog: any strobe restarts it and clears failsafe, expiry sets failsafe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt_reg <= '0;
      failsafe_reg    <= 1'b1;
    end else if (channel_changed) begin
      timeout_cnt_reg <= '0;
      failsafe_reg    <= 1'b0;
    end else if (timeout_cnt_reg != TIMEOUT_LIMIT) begin
      timeout_cnt_reg <= timeout_cnt_reg + TIMEOUT_W'(1);
      if (timeout_cnt_reg == TIMEOUT_LIMIT - TIMEOUT_W'(1)) begin
        failsafe_reg <= 1'b1;
      end
    end
  end

  // Remember one tick that arrives while a frame is in progress; IDLE consumes it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      pending_reg <= 1'b0;
    end else if (tick) begin
      pending_reg <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (frame_req && !failsafe_reg) state_next = ST_STEP;
      ST_STEP: if (step_k_reg == 2'd3) state_next = ST_WAIT;
      ST_WAIT: if (!writer_busy) state_next = ST_SEND;
      ST_SEND: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    send    = (state_reg == ST_SEND);
    step_en = (state_reg == ST_STEP);
  end

  // Output slot counter: walks 0..3 during STEP, parked at 0 otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_k_reg <= '0;
    end else if (step_en) begin
      step_k_reg <= step_k_reg + 2'd1;
    end else begin
      step_k_reg <= '0;
    end
  end

  // Move the selected position toward its target by at most max_step
  always_comb begin
    cur_pos    = pos_flat[32'(step_k_reg) * 12 +: 12];
    cur_tgt    = target_flat[32'(step_k_reg) * 12 +: 12];
    step_delta = $signed({1'b0, cur_tgt}) - $signed({1'b0, cur_pos});
    if (step_delta > STEP_HI) begin
      step_pos = cur_pos + 12'(max_step);
    end else if (step_delta < STEP_LO) begin
      step_pos = cur_pos - 12'(max_step);
    end else begin
      step_pos = cur_tgt;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [11:0] target_reg;
      logic [11:0] pos_reg;

      // Target for this channel, written by the last pipeline stage
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          target_reg <= POS_CENTER12;
        end else if (tgt_wr_en && (s2_index_reg[1:0] == 2'(gi))) begin
          target_reg <= tgt_value;
        end
      end

      // Goal position for this channel, changed only in its STEP slot
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pos_reg <= POS_CENTER12;
        end else if (step_en && (step_k_reg == 2'(gi))) begin
          pos_reg <= step_pos;
        end
      end

      assign target_flat[gi*12 +: 12] = target_reg;
      assign pos_flat[gi*12 +: 12]    = pos_reg;
    end
  endgenerate

  assign position1 = {20'b0, pos_flat[11:0]};
  assign position2 = {20'b0, pos_flat[23:12]};
  assign position3 = {20'b0, pos_flat[35:24]};
  assign position4 = {20'b0, pos_flat[47:36]};
  assign failsafe  = failsafe_reg;

endmodule

// File: tb/tb_rc_position_mapper.sv
// Testbench for rc_position_mapper: random channel updates scored against a
// frame-level reference model; a monitor checks every send pulse.
module tb_rc_position_mapper;

  localparam int P = 50;     // frame period used for simulation
  localparam int T = 3500;   // link timeout used for simulation

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        channel_changed = 1'b0;
  logic [3:0]  channel_index = '0;
  logic [10:0] channel_value = '0;
  logic        writer_busy = 1'b0;
  logic        send;
  logic [31:0] position1, position2, position3, position4;
  logic        failsafe;

  rc_position_mapper #(
    .clocks_per_update(P),
    .timeout_clocks   (T),
    .channel_center   (992),
    .scale            (40),
    .pos_center       (2048),
    .pos_min          (0),
    .pos_max          (4095),
    .max_step         (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .channel_changed(channel_changed),
    .channel_index  (channel_index),
    .channel_value  (channel_value),
    .writer_busy    (writer_busy),
    .send           (send),
    .position1      (position1),
    .position2      (position2),
    .position3      (position3),
    .position4      (position4),
    .failsafe       (failsafe)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] exp_q[$];
  int          model_tgt[4];
  int          model_pos[4];
  int          last_val[4];
  bit          free_run = 1'b0;
  int          send_count = 0;
  bit          prev_send = 1'b0;
  logic [47:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference mapping: center offset times 2.5, floor, clamp to 0..4095
  function automatic int tgt_of(input int v);
    int p, q, t;
    p = (v - 992) * 40;
    if (p >= 0) q = p / 16;
    else        q = -((-p + 15) / 16);
    t = 2048 + q;
    if (t < 0)    t = 0;
    if (t > 4095) t = 4095;
    return t;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      model_tgt[c] = 2048;
      model_pos[c] = 2048;
      last_val[c]  = 992;
    end
  endtask

  // Each expected frame: every position moves toward its target by at most 16
  task automatic push_frames(input int n);
    int d;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 4; c++) begin
        d = model_tgt[c] - model_pos[c];
        if (d > 16)       model_pos[c] += 16;
        else if (d < -16) model_pos[c] -= 16;
        else              model_pos[c] = model_tgt[c];
      end
      exp_q.push_back({12'(model_pos[3]), 12'(model_pos[2]), 12'(model_pos[1]), 12'(model_pos[0])});
    end
  endtask

  function automatic int frames_needed();
    int m, d;
    m = 0;
    for (int c = 0; c < 4; c++) begin
      d = model_tgt[c] - model_pos[c];
      if (d < 0) d = -d;
      if ((d + 15) / 16 > m) m = (d + 15) / 16;
    end
    return m;
  endfunction

  task automatic drain();
    int budget, cyc;
    budget = exp_q.size() * (P + 20) + 2 * P;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_drain: outstanding=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive(input int idx, input int val);
    channel_changed = 1'b1;
    channel_index   = 4'(idx);
    channel_value   = 11'(val);
    if (idx < 4) begin
      model_tgt[idx] = tgt_of(val);
      last_val[idx]  = val;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic end_strobe();
    channel_changed = 1'b0;
  endtask

  // Runs n frames in chunks, refreshing the link with a channel-7 strobe between chunks
  task automatic run_frames(input int n);
    int m;
    while (n > 0) begin
      m = (n > 60) ? 60 : n;
      push_frames(m);
      drain();
      @(posedge clock);
      #1;
      drive(7, 1811);
      end_strobe();
      n -= m;
    end
  endtask

  // Monitor: every send pulse is scored against the next expected frame
  always @(negedge clock) begin
    if (reset_n && send) begin
      send_count++;
      chk("send_single_cycle", 32'(prev_send), 32'd0);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("frame %0d: pos=%0d %0d %0d %0d", send_count, position1, position2, position3, position4);
        chk("frame_pos1", position1, {20'b0, mon_e[11:0]});
        chk("frame_pos2", position2, {20'b0, mon_e[23:12]});
        chk("frame_pos3", position3, {20'b0, mon_e[35:24]});
        chk("frame_pos4", position4, {20'b0, mon_e[47:36]});
      end else if (free_run) begin
        chk("hold_pos1", position1, 32'(model_pos[0]));
        chk("hold_pos2", position2, 32'(model_pos[1]));
        chk("hold_pos3", position3, 32'(model_pos[2]));
        chk("hold_pos4", position4, 32'(model_pos[3]));
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_send: actual=1 required=0 at %0t", $time);
      end
    end
    prev_send = send;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int got;
    logic [47:0] exp_a;
    model_reset();

    // Reset state, and no frames while the link has never been seen
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_pos1", position1, 32'd2048);
    chk("reset_pos2", position2, 32'd2048);
    chk("reset_pos3", position3, 32'd2048);
    chk("reset_pos4", position4, 32'd2048);
    chk("reset_send", 32'(send), 32'd0);
    chk("reset_failsafe", 32'(failsafe), 32'd1);
    reset_n = 1'b1;
    c0 = send_count;
    repeat (3 * P + 10) @(negedge clock);
    chk("no_send_in_failsafe", 32'(send_count - c0), 32'd0);
    chk("failsafe_before_link", 32'(failsafe), 32'd1);

    // Back-to-back strobes, including an unused channel; full ramps to both rails
    @(posedge clock);
    #1;
    drive(0, 1811);
    drive(1, 172);
    drive(7, 1811);
    drive(2, 992);
    drive(3, 992);
    end_strobe();
    @(negedge clock);
    chk("failsafe_cleared", 32'(failsafe), 32'd0);
    run_frames(128);
    @(negedge clock);
    chk("ramp_pos1_top", position1, 32'd4095);
    chk("ramp_pos2_bottom", position2, 32'd0);
    chk("ramp_pos3_center", position3, 32'd2048);
    chk("ramp_pos4_center", position4, 32'd2048);

    // Random back-to-back updates on all channels
    for (int r = 0; r < 2; r++) begin
      @(posedge clock);
      #1;
      drive(0, int'($urandom_range(0, 2047)));
      drive(1, int'($urandom_range(0, 2047)));
      drive(8 + int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)));
      drive(2, int'($urandom_range(0, 2047)));
      drive(3, int'($urandom_range(0, 2047)));
      end_strobe();
      run_frames(20);
    end

    // Busy writer: one frame waits, one tick is remembered, the rest are dropped
    @(posedge clock);
    #1;
    drive(0, (model_pos[0] > 2048) ? 172 : 1811);
    end_strobe();
    writer_busy = 1'b1;
    push_frames(2);
    exp_a = exp_q[0];
    c0 = send_count;
    repeat (5 * P) @(negedge clock);
    chk("busy_no_send", 32'(send_count - c0), 32'd0);
    chk("busy_frozen_pos1", position1, {20'b0, exp_a[11:0]});
    @(posedge clock);
    #1;
    writer_busy = 1'b0;
    got = 0;
    for (int i = 0; i < 2 && got == 0; i++) begin
      @(negedge clock);
      if (send) got = 1;
    end
    chk("send_after_release", 32'(got), 32'd1);
    drain();
    run_frames(1);

    // Link loss: unused-channel strobes keep the link alive, silence trips failsafe
    run_frames(frames_needed());
    free_run = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      drive(7, int'($urandom_range(0, 2047)));
      end_strobe();
      repeat (1000) @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("ch7_keeps_link", 32'(failsafe), 32'd0);
    repeat (T + 4 * P) @(negedge clock);
    chk("timeout_failsafe", 32'(failsafe), 32'd1);
    c0 = send_count;
    repeat (4 * P) @(negedge clock);
    chk("timeout_no_send", 32'(send_count - c0), 32'd0);
    chk("timeout_hold_pos1", position1, 32'(model_pos[0]));
    chk("timeout_hold_pos2", position2, 32'(model_pos[1]));
    chk("timeout_hold_pos3", position3, 32'(model_pos[2]));
    chk("timeout_hold_pos4", position4, 32'(model_pos[3]));
    free_run = 1'b0;
    push_frames(1);
    @(posedge clock);
    #1;
    drive(0, last_val[0]);
    end_strobe();
    @(negedge clock);
    chk("relink_failsafe", 32'(failsafe), 32'd0);
    drain();

    // Reset in the middle of a ramp
    @(posedge clock);
    #1;
    drive(1, (model_pos[1] < 2048) ? 1811 : 172);
    end_strobe();
    push_frames(3);
    drain();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_pos1", position1, 32'd2048);
    chk("midreset_pos2", position2, 32'd2048);
    chk("midreset_pos3", position3, 32'd2048);
    chk("midreset_pos4", position4, 32'd2048);
    chk("midreset_send", 32'(send), 32'd0);
    chk("midreset_failsafe", 32'(failsafe), 32'd1);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    c0 = send_count;
    repeat (3 * P) @(negedge clock);
    chk("post_reset_no_send", 32'(send_count - c0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
